// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin arbiter that drives the select of a downstream
// 4:1 mux and hands one channel at a time to a single consumer.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous active-high reset
//   req[3:0]   - per-channel request (bit i = mux input i holds data)
//   out_ready  - consumer accepts the selected channel this cycle
//   sel[1:0]   - registered mux select
//   out_valid  - registered; sel is committed and the mux output is valid
//   gnt[3:0]   - registered one-hot pulse naming the channel that just completed
//   xfer_count - registered count of completed transfers (wraps silently)
module rr_sel_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [3:0]       gnt,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    // Search last+1, last+2, last+3, last (2-bit wrap); first set bit wins.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        gnt_d   = 4'b0000;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (req != 4'b0000) begin
                    sel_d   = winner;
                    valid_d = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // A dropped request aborts even if the consumer is ready.
                if (!req[sel_q]) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (out_ready) begin
                    gnt_d   = 4'b0001 << sel_q;
                    valid_d = 1'b0;
                    last_d  = sel_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
            last_q  <= 2'b11;  // channel 0 gets first priority
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign sel        = sel_q;
    assign out_valid  = valid_q;
    assign gnt        = gnt_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter with hand-computed expectations.
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic [3:0] gnt;
    logic [7:0] xfer_count;

    int n_cmp;
    int n_fail;

    rr_sel_arbiter #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .out_ready  (out_ready),
        .sel        (sel),
        .out_valid  (out_valid),
        .gnt        (gnt),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_sel, input logic e_valid,
                             input logic [3:0] e_gnt, input logic [7:0] e_cnt);
        check({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".cnt"}, 32'(xfer_count), 32'(e_cnt));
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;

        // Reset held two cycles with all requests and ready asserted.
        step();
        check_all("rst1", 2'd0, 1'b0, 4'b0000, 8'd0);
        step();
        check_all("rst2", 2'd0, 1'b0, 4'b0000, 8'd0);

        // Round robin: grant then gnt pulse, alternating, rotating 0..3.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all($sformatf("rr_grant%0d", i), 2'(i), 1'b1, 4'b0000, 8'(i));
            step();
            check_all($sformatf("rr_xfer%0d", i), 2'(i), 1'b0, 4'(4'b0001 << i), 8'(i + 1));
        end

        // Backpressure on channel 2 (last=3 -> search 0,1,2).
        req       = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_all($sformatf("bp_hold%0d", i), 2'd2, 1'b1, 4'b0000, 8'd4);
        end
        out_ready = 1'b1;
        step();
        check_all("bp_xfer", 2'd2, 1'b0, 4'b0100, 8'd5);

        // Idle with no requests; ready must be ignored, sel holds.
        req = 4'b0000;
        step();
        check_all("idle_noreq", 2'd2, 1'b0, 4'b0000, 8'd5);

        // Abort: last=2, req=0010 -> sel=1; drop it with ready=1.
        req = 4'b0010;
        step();
        check_all("ab_grant", 2'd1, 1'b1, 4'b0000, 8'd5);
        req = 4'b0000;
        step();
        check_all("ab_drop", 2'd1, 1'b0, 4'b0000, 8'd5);

        // last still 2: req=0110 searches 3,0,1 -> 1 (would be 2 if last had moved).
        req       = 4'b0110;
        out_ready = 1'b0;
        step();
        check_all("ab_regrant", 2'd1, 1'b1, 4'b0000, 8'd5);
        // Other request bits changing during GRANT have no effect.
        req = 4'b1011;
        step();
        check_all("other_bits", 2'd1, 1'b1, 4'b0000, 8'd5);
        out_ready = 1'b1;
        step();
        check_all("ab_xfer", 2'd1, 1'b0, 4'b0010, 8'd6);

        // Skip/wrap: last=1, req=1010 -> 3, then 1, then 3, then 1.
        req = 4'b1010;
        step();
        check_all("sw_g3a", 2'd3, 1'b1, 4'b0000, 8'd6);
        step();
        check_all("sw_x3a", 2'd3, 1'b0, 4'b1000, 8'd7);
        step();
        check_all("sw_g1", 2'd1, 1'b1, 4'b0000, 8'd7);
        step();
        check_all("sw_x1", 2'd1, 1'b0, 4'b0010, 8'd8);
        step();
        check_all("sw_g3b", 2'd3, 1'b1, 4'b0000, 8'd8);
        step();
        check_all("sw_x3b", 2'd3, 1'b0, 4'b1000, 8'd9);
        step();
        check_all("sw_g1b", 2'd1, 1'b1, 4'b0000, 8'd9);

        // Reset on what would be a transfer edge: no pulse, no count.
        rst = 1'b1;
        step();
        check_all("rst_xfer", 2'd0, 1'b0, 4'b0000, 8'd0);

        // First arbitration after reset: last=3 -> 0,1,2 -> 2.
        rst       = 1'b0;
        req       = 4'b0100;
        out_ready = 1'b0;
        step();
        check_all("mid_grant", 2'd2, 1'b1, 4'b0000, 8'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        check_all("mid_rst", 2'd0, 1'b0, 4'b0000, 8'd0);

        // Counter wrap: 256 transfers on channel 0.
        rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 255; i++) begin
            step();
            step();
        end
        check("wrap_255", 32'(xfer_count), 32'd255);
        step();
        check("wrap_g_valid", 32'(out_valid), 32'd1);
        step();
        check_all("wrap_0", 2'd0, 1'b0, 4'b0001, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-transfer counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 req  input  4  per-channel request; bit i = channel i (a,b,c,d of the downstream 4:1 mux) holds data.
REQ-005 out_ready  input  1  downstream consumer accepts the currently selected channel this cycle.
REQ-006 sel  output  2  registered select driven to the downstream 4:1 mux sel port.
REQ-007 out_valid  output  1  registered; sel is committed and mux output is valid.
REQ-008 gnt  output  4  registered one-hot, one-cycle pulse naming the channel whose transfer completed.
REQ-009 xfer_count  output  CNT_W  registered count of completed transfers.

Function
REQ-010 Two states SHALL exist: IDLE and GRANT; state, sel, out_valid, gnt, xfer_count and priority pointer last SHALL all be flops.
REQ-011 IDLE: if req==0, remain IDLE, out_valid=0, sel holds its previous value.
REQ-012 IDLE with req!=0: winner = first set bit searching (last+1), (last+2), (last+3), last, modulo 4; next cycle sel=winner, out_valid=1, state=GRANT.
REQ-013 Arbitration latency SHALL be exactly 1 cycle from req sampled in IDLE to out_valid=1.
REQ-014 GRANT: sel and out_valid SHALL remain stable while req[sel]=1 and out_ready=0, for any number of cycles.
REQ-015 Transfer: in GRANT, out_valid=1 & out_ready=1 & req[sel]=1 on an edge -> next cycle gnt=one-hot(sel) for exactly one cycle, out_valid=0, last=sel, xfer_count+1, state=IDLE.
REQ-016 After every transfer one IDLE bubble cycle SHALL occur (out_valid=0) before the next grant; max throughput one transfer per 2 cycles.
REQ-017 Abort: in GRANT, req[sel]=0 on an edge (regardless of out_ready) -> next cycle out_valid=0, state=IDLE, gnt=0, last and xfer_count unchanged.
REQ-018 Abort SHALL take precedence over transfer when req[sel]=0 and out_ready=1 in the same cycle.
REQ-019 Changes on req bits other than req[sel] during GRANT SHALL have no effect.
REQ-020 out_ready while out_valid=0 SHALL be ignored.
REQ-021 gnt SHALL be 0 in every cycle except the single cycle after a transfer; never more than one bit set.
REQ-022 xfer_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-023 Fairness: with all four req held high and out_ready=1, grants SHALL rotate 0,1,2,3,0,... with no channel starved.

Reset
REQ-024 rst=1 on an edge SHALL force: state=IDLE, sel=2'b00, out_valid=0, gnt=4'b0000, xfer_count=0, last=2'b11 (channel 0 has first priority).
REQ-025 rst SHALL override all other inputs, including mid-GRANT and on a transfer cycle (no gnt pulse, no count increment).
REQ-026 First arbitration SHALL occur on the first edge with rst=0.

Verification
REQ-027 Reset: rst=1 for 2 cycles with req=4'b1111, out_ready=1 -> sel=0, out_valid=0, gnt=0, xfer_count=0 throughout.
REQ-028 Round-robin: after reset req=4'b1111, out_ready=1 for 8 cycles -> gnt pulses 0001,0010,0100,1000 on alternating cycles, xfer_count=4.
REQ-029 Backpressure: req=4'b0100, out_ready=0 for 5 cycles then 1 -> sel=2 and out_valid=1 stable 6 cycles, then gnt=4'b0100 one cycle, xfer_count+1.
REQ-030 Abort: granted channel 1 (req=4'b0010), drop req[1] with out_ready=1 same cycle -> out_valid=0 next cycle, gnt=0, xfer_count unchanged; next grant still searches from channel 0 priority order.
REQ-031 Skip/wrap: last=3, req=4'b1010 -> sel=1; after transfer req=4'b1010 -> sel=3; after transfer -> sel=1.
REQ-032 Reset mid-GRANT: sel=2, out_valid=1, assert rst with out_ready=1 -> no gnt pulse, sel=0, xfer_count=0 next cycle.
